sr_button_conditioner: RTL and testbench
========================================

# sr_button_conditioner

Input conditioning stage that sits directly upstream of the `sr_flip` SR flip-flop and drives its S and R inputs. It takes two raw, asynchronous, bouncy pushbutton levels (set and reset buttons) and synchronizes each to `clk`, then debounces it. Each accepted press becomes a single-cycle S or R pulse. Simultaneous presses are arbitrated so that the downstream flip-flop never sees S=R=1.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive stable synchronized samples required to accept a press or a release; legal range 2..65535.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizer; legal range 2..4.
- `CNT_W`, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width; derived, not overridden.
- `clk`  input  1  single system clock; all state is updated on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `btn_set`  input  1  raw set button, asynchronous to `clk`, active-high.
- `btn_rst`  input  1  raw reset button, asynchronous to `clk`, active-high.
- `S`  output  1  one-cycle set pulse to the flip-flop, registered.
- `R`  output  1  one-cycle reset pulse to the flip-flop, registered.
- `conflict`  output  1  one-cycle pulse, registered; both presses were accepted on the same edge and both pulses were suppressed.
- `set_held`  output  1  debounced level of `btn_set`.
- `rst_held`  output  1  debounced level of `btn_rst`.

## Operation
- Each channel runs its own synchronizer, debounce FSM and counter. The two channels are identical.
- FSM states:
  - IDLE: released. Synced input = 1 → CHECK_PRESS, counter = 1.
  - CHECK_PRESS: synced = 1 → counter increments. When the counter reaches DEBOUNCE_CYCLES → PRESSED, assert `press_acc` for one cycle, counter = 0. Synced = 0 at any point → IDLE, counter = 0 (this is a bounce).
  - PRESSED: synced = 0 → CHECK_RELEASE, counter = 1.
  - CHECK_RELEASE: synced = 0 → counter increments. When the counter reaches DEBOUNCE_CYCLES → IDLE. Synced = 1 at any point → PRESSED, counter = 0.
- `set_held` / `rst_held` are 1 in PRESSED and CHECK_RELEASE, 0 otherwise. They are registered.
- Arbiter, one registered stage:
  - Only the set channel accepts a press → `S` = 1.
  - Only the reset channel accepts a press → `R` = 1.
  - Both accept on the same edge → `S` = `R` = 0 and `conflict` = 1.
- `S` and `R` are never 1 in the same cycle under any input sequence.
- A held button produces exactly one pulse. Auto-repeat is not supported.
- The counter saturates logic-wise at DEBOUNCE_CYCLES and never wraps.

## Timing
- Reset (`rst_n` = 0): synchronizer flops = 0, FSMs = IDLE, counters = 0. `S`, `R`, `conflict`, `set_held`, `rst_held` are all 0 immediately, without waiting for a clock edge.
- Latency: a clean rise sampled at edge k produces `S`/`R` high during the cycle after edge k + SYNC_STAGES + DEBOUNCE_CYCLES. The pulse width is exactly one `clk` cycle.
- Release latency to `*_held` = 0 is SYNC_STAGES + DEBOUNCE_CYCLES edges.
- A release that is still in CHECK_RELEASE does not enable a new press; a new pulse requires a full return to IDLE first.
- Presses accepted one cycle apart are not a conflict: `S` and `R` pulse on consecutive cycles.
- Reset asserted mid-operation aborts the current state; no pulse is emitted. After `rst_n` deasserts, a button that is still held is treated as a fresh press and pulses after the full latency.

## Structure
- Shared package `sr_cond_pkg` holds:
  - the FSM state encoding constants (IDLE = 2'd0, CHECK_PRESS = 2'd1, PRESSED = 2'd2, CHECK_RELEASE = 2'd3);
  - the default DEBOUNCE_CYCLES constant.
- Sub-module `debounce_channel` (parameters SYNC_STAGES, DEBOUNCE_CYCLES; ports `clk`, `rst_n`, `raw`, `press_acc`, `held`) is instantiated twice.
- The arbiter and output registers live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and SYNC_STAGES = 2; the 20 ns clock period matches the existing bench.
- Clean press: `btn_set` 0→1 at edge 0 and held → `S` = 1 during cycle 7 only, `set_held` = 1 from cycle 6 on, `R` = `conflict` = 0 throughout.
- Bounce: `btn_set` high for 3 cycles, low for 1, then high and held → no pulse until 7 cycles after the final rise; exactly one `S` pulse.
- Simultaneous: `btn_set` and `btn_rst` rise on the same edge and are held → `conflict` = 1 for one cycle, `S` = `R` = 0 for the whole run.
- Staggered: `btn_rst` rises one cycle after `btn_set` → `S` pulses in cycle 7, `R` pulses in cycle 8, `conflict` = 0.
- Release/re-press: press and hold for 10 cycles, release for 2 cycles, re-press → no second `S`. Then release for 8 cycles and re-press → a second `S` 7 cycles after the re-press.
- Reset mid-press: `rst_n` = 0 during CHECK_PRESS → all outputs 0 immediately. After `rst_n` = 1 with the button still held → `S` pulses 7 cycles after the first post-reset edge.

Source files
------------

// File: rtl/sr_cond_pkg.sv
// Shared definitions for the SR flip-flop input conditioner: debounce FSM encoding and defaults.
package sr_cond_pkg;

   typedef enum logic [1:0] {
      StIdle         = 2'd0,
      StCheckPress   = 2'd1,
      StPressed      = 2'd2,
      StCheckRelease = 2'd3
   } state_e;

   localparam int unsigned DefaultDebounceCycles = 1000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: multi-flop synchronizer, then a debounce FSM that emits a single-cycle
// press_acc per accepted press and a registered debounced level.
module debounce_channel
   import sr_cond_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press_acc,
   output logic held
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   synced;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   press_q, press_d;
   logic                   held_q, held_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= StIdle;
         cnt_q   <= '0;
         press_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         held_q  <= held_d;
      end
   end

   // The count includes the sample that left the stable state, so the last stable sample
   // is the one seen while cnt_q == DEBOUNCE_CYCLES-1; the counter therefore never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (synced) begin
               state_d = StCheckPress;
               cnt_d   = CNT_W'(1);
            end
         end
         StCheckPress: begin
            if (!synced) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StPressed: begin
            if (!synced) begin
               state_d = StCheckRelease;
               cnt_d   = CNT_W'(1);
            end
         end
         StCheckRelease: begin
            if (synced) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      press_d = (state_q == StCheckPress) && synced && (cnt_q == CntLast);
      held_d  = (state_d == StPressed) || (state_d == StCheckRelease);
   end

   assign press_acc = press_q;
   assign held      = held_q;

endmodule

// File: rtl/sr_button_conditioner.sv
// Conditions raw set/reset buttons into single-cycle S/R pulses; same-edge presses are dropped
// and flagged so the downstream SR flip-flop never sees S and R together.
module sr_button_conditioner
   import sr_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set,
   input  logic btn_rst,
   output logic S,
   output logic R,
   output logic conflict,
   output logic set_held,
   output logic rst_held
);

   logic set_acc, rst_acc;
   logic s_q, s_d, r_q, r_d, conflict_q, conflict_d;

   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_set_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (btn_set),
      .press_acc (set_acc),
      .held      (set_held)
   );

   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_rst_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (btn_rst),
      .press_acc (rst_acc),
      .held      (rst_held)
   );

   always_comb begin
      s_d        = set_acc && !rst_acc;
      r_d        = rst_acc && !set_acc;
      conflict_d = set_acc && rst_acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         s_q        <= s_d;
         r_q        <= r_d;
         conflict_q <= conflict_d;
      end
   end

   assign S        = s_q;
   assign R        = r_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Directed bench for sr_button_conditioner: expected pulses are queued as stimulus is applied
// and matched against every S/R/conflict pulse the DUT emits.
module tb_sr_button_conditioner;

   localparam int unsigned Db   = 4;
   localparam int unsigned Sync = 2;
   localparam int          Lat  = Sync + Db;
   localparam int          EvS  = 0;
   localparam int          EvR  = 1;
   localparam int          EvC  = 2;

   typedef struct {
      int kind;
      int cyc;
   } evt_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic btn_set = 1'b0;
   logic btn_rst = 1'b0;
   logic S, R, conflict, set_held, rst_held;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   evt_t sb[$];

   sr_button_conditioner #(
      .DEBOUNCE_CYCLES (Db),
      .SYNC_STAGES     (Sync)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_set  (btn_set),
      .btn_rst  (btn_rst),
      .S        (S),
      .R        (R),
      .conflict (conflict),
      .set_held (set_held),
      .rst_held (rst_held)
   );

   always #10 clk = ~clk;

   // cyc holds the index of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic expect_evt(input int kind, input int at);
      evt_t e;
      e.kind = kind;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic got_evt(input int kind);
      evt_t e;
      checks++;
      assert (sb.size() > 0) else begin
         failures++;
         $error("FAIL unexpected_pulse observed kind=%0d cyc=%0d expected=none", kind, cyc);
         return;
      end
      e = sb.pop_front();
      assert (e.kind == kind && e.cyc == cyc) else begin
         failures++;
         $error("FAIL pulse observed kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                kind, cyc, e.kind, e.cyc);
      end
   endtask

   task automatic sb_empty(input string tag);
      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL %s_missing_pulses observed pending=%0d expected=0", tag, sb.size());
         sb.delete();
      end
   endtask

   // Returns at the falling edge that follows rising edge n.
   task automatic at_edge(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (S === 1'b1) got_evt(EvS);
            if (R === 1'b1) got_evt(EvR);
            if (conflict === 1'b1) got_evt(EvC);
         end
      end
   endtask

   task automatic settle(input string tag);
      btn_set = 1'b0;
      btn_rst = 1'b0;
      at_edge(cyc + Lat + 4);
      chk({tag, "_set_held_rel"}, set_held, 1'b0);
      chk({tag, "_rst_held_rel"}, rst_held, 1'b0);
      sb_empty(tag);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_S"}, S, 1'b0);
      chk({tag, "_R"}, R, 1'b0);
      chk({tag, "_conflict"}, conflict, 1'b0);
      chk({tag, "_set_held"}, set_held, 1'b0);
      chk({tag, "_rst_held"}, rst_held, 1'b0);
   endtask

   initial begin
      int b;
      int r;
      int p;
      fork
         monitor();
      join_none

      // Reset values appear without a clock edge.
      #2 rst_n = 1'b0;
      #2 chk_all_zero("reset");
      at_edge(2);
      rst_n = 1'b1;
      at_edge(5);

      // Clean press, then release.
      b = cyc + 1;
      btn_set = 1'b1;
      expect_evt(EvS, b + Lat);
      at_edge(b + Lat - 2);
      chk("clean_held_early", set_held, 1'b0);
      at_edge(b + Lat - 1);
      chk("clean_held", set_held, 1'b1);
      chk("clean_rst_held", rst_held, 1'b0);
      at_edge(b + Lat + 4);
      btn_set = 1'b0;
      r = b + Lat + 5;
      at_edge(r + Lat - 2);
      chk("clean_held_in_release", set_held, 1'b1);
      at_edge(r + Lat - 1);
      chk("clean_held_released", set_held, 1'b0);
      settle("clean");

      // Bounce: 3 high, 1 low, then held.
      b = cyc + 1;
      btn_set = 1'b1;
      at_edge(b + 2);
      btn_set = 1'b0;
      at_edge(b + 3);
      btn_set = 1'b1;
      expect_evt(EvS, b + 4 + Lat);
      at_edge(b + 4 + Lat - 2);
      chk("bounce_held_early", set_held, 1'b0);
      at_edge(b + 4 + Lat - 1);
      chk("bounce_held", set_held, 1'b1);
      at_edge(b + 4 + Lat + 3);
      settle("bounce");

      // Simultaneous presses.
      b = cyc + 1;
      btn_set = 1'b1;
      btn_rst = 1'b1;
      expect_evt(EvC, b + Lat);
      at_edge(b + Lat - 1);
      chk("simul_set_held", set_held, 1'b1);
      chk("simul_rst_held", rst_held, 1'b1);
      at_edge(b + Lat + 4);
      settle("simul");

      // Staggered by one cycle.
      b = cyc + 1;
      btn_set = 1'b1;
      expect_evt(EvS, b + Lat);
      at_edge(b);
      btn_rst = 1'b1;
      expect_evt(EvR, b + 1 + Lat);
      at_edge(b + Lat + 4);
      settle("stagger");

      // Short release does not re-arm; a full release does.
      b = cyc + 1;
      btn_set = 1'b1;
      expect_evt(EvS, b + Lat);
      at_edge(b + 9);
      btn_set = 1'b0;
      at_edge(b + 11);
      btn_set = 1'b1;
      at_edge(b + 13);
      chk("repress_held_check_release", set_held, 1'b1);
      at_edge(b + 15);
      chk("repress_held_back", set_held, 1'b1);
      at_edge(b + 19);
      btn_set = 1'b0;
      r = b + 20;
      at_edge(r + 6);
      chk("repress_released", set_held, 1'b0);
      at_edge(r + 7);
      btn_set = 1'b1;
      expect_evt(EvS, r + 8 + Lat);
      at_edge(r + 8 + Lat + 3);
      settle("repress");

      // Reset during CHECK_PRESS, button still held afterwards.
      b = cyc + 1;
      btn_set = 1'b1;
      at_edge(b + 3);
      #3 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      at_edge(b + 5);
      rst_n = 1'b1;
      p = b + 6;
      expect_evt(EvS, p + Lat);
      at_edge(p + Lat + 2);
      chk("postreset_held", set_held, 1'b1);
      #3 rst_n = 1'b0;
      #1 chk("async_reset_held", set_held, 1'b0);
      at_edge(p + Lat + 4);
      rst_n = 1'b1;
      p = p + Lat + 5;
      expect_evt(EvS, p + Lat);
      at_edge(p + Lat + 3);
      settle("midreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100us;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
